// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK flop-bank excitation driver.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Minimal JK excitation for one bit: set when rising, reset when falling, else hold.
  // Toggle (J=K=1) is never produced.
  function automatic logic [1:0] jk_excite(input logic q, input logic d);
    return {~q & d, q & ~d};
  endfunction

endpackage

// File: rtl/jk_target_fifo.sv
// Synchronous FIFO holding target words; first-word fall-through read port.
module jk_target_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_c, pop_ok_c;

  // Status flags and head-of-queue read.
  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
    empty_c   = (count_q == '0);
    push_ok_c = push & ~full_c;
    pop_ok_c  = pop & ~empty_c;
    dout_c    = mem[rd_ptr_q];
    count     = count_q;
  end

  // Pointer and occupancy update; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= din;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flops through queued targets and checks their response.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] qbar_fb,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             rail_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             rail_err_q, rail_err_d;

  logic [WIDTH-1:0] fifo_dout_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [CW-1:0]    fifo_count;
  logic             push_c, pop_c;
  logic [WIDTH-1:0] exc_j_c, exc_k_c;

  jk_target_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (in_target),
    .dout_c  (fifo_dout_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  // Handshake and activity status.
  always_comb begin
    in_ready = ~fifo_full_c;
    push_c   = in_valid & ~fifo_full_c;
    busy     = (state_q != IDLE) | (fifo_count != '0);
  end

  // Per-bit excitation of the head target against the current flop outputs.
  always_comb begin
    exc_j_c = '0;
    exc_k_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {exc_j_c[i], exc_k_c[i]} = jk_excite(q_fb[i], fifo_dout_c[i]);
    end
  end

  // Sequencer: pop and drive for one cycle, let the flops settle, then check.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    j_d         = '0;
    k_d         = '0;
    mismatch_d  = 1'b0;
    err_count_d = err_count_q;
    rail_err_d  = rail_err_q;
    pop_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c    = 1'b1;
          target_d = fifo_dout_c;
          j_d      = exc_j_c;
          k_d      = exc_k_c;
          state_d  = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        mismatch_d = (q_fb != target_q);
        if (mismatch_d && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
        if (qbar_fb != ~q_fb) rail_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides a coincident increment or rail fault.
    if (clear) begin
      err_count_d = '0;
      rail_err_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      j_q         <= '0;
      k_q         <= '0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
      rail_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      j_q         <= j_d;
      k_q         <= k_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
      rail_err_q  <= rail_err_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
  assign rail_err  = rail_err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench: JK flop bank looped back through the driver, scoreboarded targets.
module tb_jk_excitation_driver;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_target;
  logic [3:0] j, k;
  logic [3:0] q_fb, qbar_fb;
  logic       busy;
  logic       mismatch;
  logic [7:0] err_count;
  logic       rail_err;

  // External flop bank and fault injection.
  logic [3:0] q_flop     = 4'b0000;
  logic [3:0] stuck_mask = 4'b0000;
  logic       rail_fault = 1'b0;

  // Scoreboard and monitor state.
  logic [3:0] sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mon_phase = 0;
  int         drive_cnt = 0;
  int         check_cnt = 0;
  logic [3:0] cur_tgt, exp_q, last_j, last_k;
  logic       exp_mm;

  jk_excitation_driver #(
    .WIDTH (4),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .busy      (busy),
    .mismatch  (mismatch),
    .err_count (err_count),
    .rail_err  (rail_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK flop behaviour: set, reset, hold, toggle.
  always @(posedge clk) q_flop <= (j & ~q_flop) | (~k & q_flop);

  assign q_fb    = q_flop & ~stuck_mask;
  assign qbar_fb = rail_fault ? {~q_fb[3], q_fb[2], ~q_fb[1:0]} : ~q_fb;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each drive pulse and follows it to its check.
  always @(negedge clk) begin
    if (!rst) begin
      mon_phase = 0;
      sb.delete();
    end else begin
      check_eq("no_toggle", 32'(j & k), 32'd0);
      case (mon_phase)
        0: begin
          if ((j | k) != 4'b0000) begin
            if (sb.size() == 0) begin
              check_eq("sb_nonempty_on_drive", 32'(sb.size()), 32'd1);
            end else begin
              cur_tgt = sb.pop_front();
              check_eq("drive_j", 32'(j), 32'(~q_fb & cur_tgt));
              check_eq("drive_k", 32'(k), 32'(q_fb & ~cur_tgt));
              last_j = j;
              last_k = k;
              drive_cnt++;
              mon_phase = 1;
            end
          end else begin
            check_eq("mismatch_quiet", 32'(mismatch), 32'd0);
          end
        end
        1: begin
          check_eq("j_one_cycle", 32'(j), 32'd0);
          check_eq("k_one_cycle", 32'(k), 32'd0);
          check_eq("mismatch_in_check", 32'(mismatch), 32'd0);
          exp_q  = cur_tgt & ~stuck_mask;
          exp_mm = (exp_q != cur_tgt);
          check_eq("flop_q", 32'(q_fb), 32'(exp_q));
          check_cnt++;
          mon_phase = 2;
        end
        default: begin
          check_eq("mismatch_pulse", 32'(mismatch), 32'(exp_mm));
          mon_phase = 0;
        end
      endcase
    end
  end

  // Offer a word once in_ready allows it; callers sit at negedge+1.
  task automatic push_wait(input logic [3:0] w);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        in_valid  = 1'b1;
        in_target = w;
        sb.push_back(w);
        @(negedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check_eq("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (!busy && sb.size() == 0 && mon_phase == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_drive();
    int  start = drive_cnt;
    bit  seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (drive_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("drive_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_check();
    int  start = check_cnt;
    bit  seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (check_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("check_seen", 32'(seen), 32'd1);
  endtask

  logic [3:0] bb_words [6] = '{4'b0011, 4'b1100, 4'b0101, 4'b1010, 4'b0110, 4'b1111};
  bit         bb_exp   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit acc;
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_target = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_j", 32'(j), 32'd0);
    check_eq("rst_k", 32'(k), 32'd0);
    check_eq("rst_mismatch", 32'(mismatch), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_rail_err", 32'(rail_err), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    // Set from all-zero flops.
    push_wait(4'b1010);
    wait_drive();
    check_eq("t1_j", 32'(last_j), 32'(4'b1010));
    check_eq("t1_k", 32'(last_k), 32'(4'b0000));
    wait_idle(20);
    check_eq("t1_q", 32'(q_fb), 32'(4'b1010));
    check_eq("t1_err_count", 32'(err_count), 32'd0);

    // Mixed set/reset/hold.
    push_wait(4'b0110);
    wait_drive();
    check_eq("t2_j", 32'(last_j), 32'(4'b0100));
    check_eq("t2_k", 32'(last_k), 32'(4'b1000));
    wait_idle(20);
    check_eq("t2_q", 32'(q_fb), 32'(4'b0110));

    // Back-to-back pushes while the sequencer is occupied: queue fills, extra word drops.
    push_wait(4'b1001);
    wait_drive();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_target = bb_words[i];
      acc = in_ready;
      if (acc) sb.push_back(bb_words[i]);
      check_eq("bb_accept", 32'(acc), 32'(bb_exp[i]));
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle(60);
    check_eq("bb_final_q", 32'(q_fb), 32'(4'b0110));
    check_eq("bb_busy_low", 32'(busy), 32'd0);

    // Stuck-at-0 flop: every check fails, counter saturates.
    stuck_mask = 4'b0001;
    push_wait(4'b1111);
    wait_idle(20);
    check_eq("stuck_err_1", 32'(err_count), 32'd1);
    for (int i = 0; i < 299; i++) push_wait(4'b1111);
    wait_idle(60);
    check_eq("stuck_err_sat", 32'(err_count), 32'd255);
    push_wait(4'b1111);
    wait_check();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_idle(20);
    check_eq("clear_wins", 32'(err_count), 32'd0);
    stuck_mask = 4'b0000;
    @(negedge clk); #1;

    // Rail fault on bit 2 is sticky until clear.
    rail_fault = 1'b1;
    push_wait(4'b0000);
    wait_idle(20);
    check_eq("rail_set", 32'(rail_err), 32'd1);
    rail_fault = 1'b0;
    push_wait(4'b1010);
    wait_idle(20);
    check_eq("rail_sticky", 32'(rail_err), 32'd1);
    check_eq("rail_no_err", 32'(err_count), 32'd0);
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    check_eq("rail_cleared", 32'(rail_err), 32'd0);

    // Reset during DRIVE aborts the pending check.
    push_wait(4'b0101);
    wait_drive();
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("abort_j", 32'(j), 32'd0);
    check_eq("abort_k", 32'(k), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_mismatch", 32'(mismatch), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("abort_no_pulse", 32'(mismatch), 32'd0);
    end
    push_wait(4'b1010);
    wait_idle(20);
    check_eq("post_reset_q", 32'(q_fb), 32'(4'b1010));
    check_eq("post_reset_err", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
